// File: rtl/cic_comb_chain.sv
// Pipelined N-stage CIC comb shared by CH interleaved channels; one register per stage, latency N.
// No backpressure: one sample per cycle, out-of-range channels dropped, i_clear flushes all state.
module cic_comb_chain #(
  parameter int IW  = 19,
  parameter int OW  = 19,
  parameter int N   = 3,
  parameter int M   = 1,
  parameter int CH  = 2,
  parameter int CHW = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           i_valid,
  input  logic [CHW-1:0] i_ch,
  input  logic [IW-1:0]  i_data,
  input  logic           i_clear,
  output logic           o_valid,
  output logic [CHW-1:0] o_ch,
  output logic [OW-1:0]  o_data
);

  // Delay memories are sized to the full index range so any i_ch value indexes legally.
  localparam int NCH = 2 ** CHW;
  localparam logic [CHW:0] CH_L = CH[CHW:0];

  logic           vld [N];
  logic [CHW-1:0] chn [N];
  logic [IW-1:0]  dat [N];
  logic [IW-1:0]  dly [N][NCH][M];

  logic           s_vld [N];
  logic [CHW-1:0] s_ch  [N];
  logic [IW-1:0]  s_dat [N];
  logic [IW-1:0]  diff  [N];
  logic           ch_ok;

  assign ch_ok = ({1'b0, i_ch} < CH_L);

  always_comb begin
    s_vld[0] = i_valid & ch_ok;
    s_ch[0]  = i_ch;
    s_dat[0] = i_data;
    for (int k = 1; k < N; k++) begin
      s_vld[k] = vld[k-1];
      s_ch[k]  = chn[k-1];
      s_dat[k] = dat[k-1];
    end
    // Wrap-around subtraction is what keeps the integrator/comb pair exact.
    for (int k = 0; k < N; k++) begin
      diff[k] = s_dat[k] - dly[k][s_ch[k]][M-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) begin
        vld[k] <= 1'b0;
        chn[k] <= '0;
        dat[k] <= '0;
        for (int c = 0; c < NCH; c++)
          for (int j = 0; j < M; j++)
            dly[k][c][j] <= '0;
      end
    end else if (i_clear) begin
      for (int k = 0; k < N; k++) begin
        vld[k] <= 1'b0;
        chn[k] <= '0;
        dat[k] <= '0;
        for (int c = 0; c < NCH; c++)
          for (int j = 0; j < M; j++)
            dly[k][c][j] <= '0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        vld[k] <= s_vld[k];
        if (s_vld[k]) begin
          chn[k] <= s_ch[k];
          dat[k] <= diff[k];
          for (int j = M - 1; j > 0; j--)
            dly[k][s_ch[k]][j] <= dly[k][s_ch[k]][j-1];
          dly[k][s_ch[k]][0] <= s_dat[k];
        end
      end
    end
  end

  assign o_valid = vld[N-1];
  assign o_ch    = chn[N-1];
  assign o_data  = dat[N-1][IW-1 -: OW];

endmodule

// File: doc/cic_comb_chain.md
# cic_comb_chain

Parametrised, pipelined comb section for the CIC decimator path: N cascaded comb stages with differential delay M, operating on time-multiplexed channels (e.g. L/R) that share one datapath. It sits after the decimating integrator/downsampler and runs in the single system clock domain. Samples are qualified by a valid strobe, not by a dedicated sample-rate clock. Output is truncated to the requested width.

## Interface
- IW, 19: input and internal bitwidth.
- OW, 19: output bitwidth; must satisfy OW <= IW.
- N, 3: number of cascaded comb stages, 1..8.
- M, 1: differential delay per stage, 1 or 2.
- CH, 2: number of interleaved channels, 1..8; CHW = max(1, clog2(CH)).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  input sample strobe.
- i_ch  in  CHW  channel index of the input sample; must be < CH.
- i_data  in  IW  two's-complement input sample.
- i_clear  in  1  synchronous flush of all delay state and pipeline.
- o_valid  out  1  output sample strobe.
- o_ch  out  CHW  channel index of the output sample.
- o_data  out  OW  two's-complement output sample.

## Operation
- Each stage k (1..N) holds its own delay memory of CH x M words of IW bits, indexed by channel.
- When stage k receives a valid sample x for channel c:
  - it outputs y = x - d[k][c][M-1], computed modulo 2^IW;
  - it shifts the line for channel c only: d[k][c][j] <= d[k][c][j-1], and d[k][c][0] <= x;
  - delay lines of other channels are untouched.
- Arithmetic is wrap-around (no saturation). Wrap-around is required for CIC correctness.
- Output: o_data = stage-N result bits [IW-1 : IW-OW] (MSB truncation, no rounding).
- Channel order is arbitrary: routing follows i_ch, not arrival order. Channels may repeat back-to-back.
- i_clear: zeroes all delay memories, and all stage valid flags and data, on the next edge. If i_valid is high in the same cycle, i_clear wins and the sample is discarded.
- i_ch >= CH: the sample is dropped and no state changes.
- Reset (async, any time, including mid-pipeline):
  - o_valid = 0, o_ch = 0, o_data = 0;
  - all delay memories = 0, all internal valid flags = 0.
  - In-flight samples are lost.

## Timing
- One register per stage. Latency from i_valid to o_valid is exactly N cycles.
- Throughput: one sample per cycle, any channel mix. No backpressure; the sink must accept every o_valid.
- o_ch and o_data are valid only while o_valid = 1. They hold their last value otherwise.
- o_valid is a single-cycle pulse per sample. Its pattern is the i_valid pattern delayed by N.
- A sample and an update to the same channel in consecutive cycles must see the updated delay line. Per-stage read-modify-write completes in one cycle.
- First output after reset or clear for each channel equals the input, because the delay is zero.

## Test plan
- N=1, M=1, CH=1, IW=OW=8: i_data 5, 7, 3 on consecutive valids -> o_data 5, 2, 0xFC; o_valid exactly 1 cycle after each input.
- N=2, M=1, CH=1: constant 10 for 5 samples -> o_data 10, 0xF6 (-10), 0, 0, 0 (second difference of a step); latency 2.
- N=1, M=2, CH=1: inputs 1, 2, 3, 4 -> outputs 1, 2, 2, 2. Wrap check with M=1, IW=OW=8: 0x7F then 0x80 -> 0x7F, 0x01.
- CH=2, N=1, M=1, interleaved (ch0:1), (ch1:10), (ch0:4), (ch1:30), then (ch1:31) back-to-back -> ch0: 1, 3; ch1: 10, 20, 1. o_ch matches each sample.
- IW=19, OW=16, N=1: input 0x00010 then 0x00030 -> o_data 0x0002, then 0x0004 (top 16 bits).
- Reset/clear: assert reset_n low while 2 samples are in flight (N=3) -> no o_valid, outputs 0 immediately. Separately, i_clear together with i_valid -> sample discarded; the next input 9 yields o_data 9.
